mcu_bank_ctrl: RTL and testbench
================================

Name: mcu_bank_ctrl

Overview:
Parametrised memory-control-unit sequencer for the 2D convolution datapath. It manages a ring of K+2 line-buffer banks:
- K banks feed the kernel.
- 1 bank loads incoming rows.
- 1 bank drains results.

It decodes the host mode code {i_eop,i_sop} into LOAD/PROC/OUT phases and produces bank write-enables, bank select and a PROC sub-phase index. Compared with the previous generation it adds kernel-size generalisation, an explicit IDLE state, block-change edge handling in every phase, and illegal-code detection.

Parameters:
K, 3, kernel height in rows; odd, ≥3
NB, K+2, number of banks (localparam, not overridable)
SUB, K/2+1, PROC sub-phases per cycle of the ring (localparam, integer division)
BW, clog2(NB) (min 1), bank index width (localparam)
SW, clog2(SUB) (min 1), sub-phase width (localparam)

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
i_sop  in  1  mode code bit 0
i_eop  in  1  mode code bit 1
i_chblk  in  1  block-change strobe; only the rising edge is significant
o_we  out  NB  per-bank write enable
o_state  out  2  00 LOAD, 01 PROC, 10 OUT, 11 IDLE
o_substate  out  SW  current PROC sub-phase
o_memSelect  out  BW  bank selected for load/readout
o_err  out  1  sticky illegal-code flag

Behaviour:
- Single clock domain, clk. Reset rst is asynchronous and active-high; all registers clear immediately on its assertion.
- Reset values:
  - state = IDLE (o_state = 2'b11)
  - load pointer wp = NB-1
  - out pointer op = NB-1
  - substate = SUB-1
  - chblk_q = 0, err = 0
  - Resulting outputs: o_we = 0, o_memSelect = 0, o_substate = SUB-1, o_err = 0.
- Code decode: code = {i_eop,i_sop}. 00 → LOAD, 01 → PROC, 10 → OUT, 11 → illegal.
- State register:
  - On each clk edge, state <= decoded code if the code is legal.
  - On code 11: state holds and err <= 1. err stays set until rst.
  - Latency: 1 cycle from code to o_state and dependent outputs.
- Entry: a clock edge where the next state is legal and differs from the current state.
  - Entry to LOAD: wp <= (wp==NB-1) ? 0 : wp+1.
  - Entry to PROC: substate <= (substate==SUB-1) ? 0 : substate+1.
  - Entry to OUT: op <= (op==NB-1) ? 0 : op+1.
  - Re-asserting the current code is not an entry; pointers hold.
- Block-change edge: edge = i_chblk & ~chblk_q. chblk_q <= i_chblk on every clk edge, in every state.
  - Edge while state==LOAD and no entry this cycle: wp advances (mod NB).
  - Edge while state==OUT and no entry this cycle: op advances (mod NB).
  - Edge in PROC or IDLE: ignored, but chblk_q still updates.
  - Edge coinciding with an entry: a single advance only, never two.
- Outputs (combinational from registered state and pointers):
  - LOAD: o_we = onehot(wp); o_memSelect = wp.
  - PROC: o_we = all ones except bits wp and op; o_memSelect = 0. If wp==op, only that single bit is cleared.
  - OUT: o_we = 0; o_memSelect = op.
  - IDLE: o_we = 0; o_memSelect = 0.
  - o_substate always equals the substate register.
- Wrap-around:
  - Pointers are modulo NB, never out of range.
  - substate is modulo SUB.
- Reset mid-operation: state returns to IDLE; pointers and err return to their reset values asynchronously.

Test Plan:
- Reset with K=3 (NB=5, SUB=2) → o_state=11, o_we=0, o_memSelect=0, o_substate=1, o_err=0.
- Code 00 held 4 cycles after reset → one cycle later o_state=00, o_we=5'b00001, o_memSelect=0; no further change while held.
- In LOAD, pulse i_chblk high for 3 cycles, then low, then high for 1 cycle → wp advances twice: o_we=00010, then 00100. Repeat 5 edges total → wraps back to 00001.
- Sequence LOAD(wp=2) → OUT → PROC → OUT → PROC:
  - First OUT: o_memSelect=0.
  - First PROC: o_we=11010, o_substate=0.
  - Second OUT: o_memSelect=1.
  - Second PROC: o_we=11001, o_substate=1.
- Code 11 applied for 1 cycle while in PROC → o_state stays 01, o_err=1 and remains 1 through later legal codes until rst.
- Entry to OUT with i_chblk rising edge in the same cycle → op advances by exactly 1. Assert rst mid-OUT → outputs return to reset values without waiting for a clk edge.

Source files
------------

// File: rtl/mcu_bank_ctrl_if.sv
// ---------------------------------------------------------------------------
// mcu_bank_ctrl_if
// Host <-> bank-sequencer bundle for the convolution line-buffer ring.
//   i_sop, i_eop : mode code {i_eop,i_sop} (00 LOAD, 01 PROC, 10 OUT, 11 illegal)
//   i_chblk      : block-change strobe; only its rising edge is significant
//   o_we         : per-bank write enable (NB bits)
//   o_state      : 00 LOAD, 01 PROC, 10 OUT, 11 IDLE
//   o_substate   : current PROC sub-phase
//   o_memSelect  : bank selected for load/readout
//   o_err        : sticky illegal-code flag
// master = host side (drives the code), slave = sequencer side.
// ---------------------------------------------------------------------------
interface mcu_bank_ctrl_if #(
    parameter int K = 3
);
    localparam int NB  = K + 2;
    localparam int SUB = K / 2 + 1;
    localparam int BW  = ($clog2(NB)  < 1) ? 1 : $clog2(NB);
    localparam int SW  = ($clog2(SUB) < 1) ? 1 : $clog2(SUB);

    logic          i_sop;
    logic          i_eop;
    logic          i_chblk;
    logic [NB-1:0] o_we;
    logic [1:0]    o_state;
    logic [SW-1:0] o_substate;
    logic [BW-1:0] o_memSelect;
    logic          o_err;

    modport master (
        output i_sop, i_eop, i_chblk,
        input  o_we, o_state, o_substate, o_memSelect, o_err
    );

    modport slave (
        input  i_sop, i_eop, i_chblk,
        output o_we, o_state, o_substate, o_memSelect, o_err
    );
endinterface

// File: rtl/mcu_bank_ctrl.sv
// ---------------------------------------------------------------------------
// mcu_bank_ctrl
// Sequencer for a ring of K+2 line-buffer banks: K banks feed the kernel,
// one bank loads incoming rows (load pointer wp) and one drains results
// (out pointer op). The host mode code selects LOAD/PROC/OUT; entering a
// phase advances that phase's pointer (or the PROC sub-phase), and a rising
// edge of i_chblk inside LOAD/OUT advances the active pointer.
// Ports:
//   clk  : clock
//   rst  : asynchronous active-high reset
//   bus  : mcu_bank_ctrl_if.slave (mode code, chblk strobe, bank controls)
// ---------------------------------------------------------------------------
module mcu_bank_ctrl #(
    parameter int K = 3
) (
    input  logic               clk,
    input  logic               rst,
    mcu_bank_ctrl_if.slave     bus
);
    localparam int NB  = K + 2;
    localparam int SUB = K / 2 + 1;
    localparam int BW  = ($clog2(NB)  < 1) ? 1 : $clog2(NB);
    localparam int SW  = ($clog2(SUB) < 1) ? 1 : $clog2(SUB);

    localparam logic [1:0]    ST_LOAD = 2'b00;
    localparam logic [1:0]    ST_PROC = 2'b01;
    localparam logic [1:0]    ST_OUT  = 2'b10;
    localparam logic [1:0]    ST_IDLE = 2'b11;

    localparam logic [BW-1:0] PTR_MAX = BW'(NB - 1);
    localparam logic [BW-1:0] PTR_ONE = BW'(1);
    localparam logic [SW-1:0] SUB_MAX = SW'(SUB - 1);
    localparam logic [SW-1:0] SUB_ONE = SW'(1);
    localparam logic [NB-1:0] WE_ONE  = NB'(1);

    logic [1:0]    r_state;
    logic [1:0]    w_state_nxt;
    logic [1:0]    w_code;
    logic          w_legal;
    logic          w_entry;
    logic          w_edge;
    logic [BW-1:0] r_wp;
    logic [BW-1:0] w_wp_nxt;
    logic [BW-1:0] r_op;
    logic [BW-1:0] w_op_nxt;
    logic [SW-1:0] r_sub;
    logic [SW-1:0] w_sub_nxt;
    logic          r_chblk_q;
    logic          r_err;
    logic [NB-1:0] w_we;
    logic [BW-1:0] w_sel;

    // Ring pointers wrap at NB-1 rather than at a power of two.
    function automatic logic [BW-1:0] f_ptr_inc(input logic [BW-1:0] p);
        return (p == PTR_MAX) ? {BW{1'b0}} : (p + PTR_ONE);
    endfunction

    function automatic logic [SW-1:0] f_sub_inc(input logic [SW-1:0] s);
        return (s == SUB_MAX) ? {SW{1'b0}} : (s + SUB_ONE);
    endfunction

    // State register: IDLE out of reset, then follows the legal mode code.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode; illegal code 11 holds the current state.
    always_comb begin
        w_code      = {bus.i_eop, bus.i_sop};
        w_legal     = (w_code != ST_IDLE);
        w_state_nxt = r_state;
        w_entry     = 1'b0;
        if (w_legal) begin
            w_state_nxt = w_code;
            w_entry     = (w_code != r_state);
        end else begin
            w_state_nxt = r_state;
            w_entry     = 1'b0;
        end
    end

    // Pointer/sub-phase update; an entry takes precedence over a chblk edge
    // so a coincident edge never produces a second advance.
    always_comb begin
        w_edge    = bus.i_chblk & ~r_chblk_q;
        w_wp_nxt  = r_wp;
        w_op_nxt  = r_op;
        w_sub_nxt = r_sub;
        if (w_entry) begin
            case (w_state_nxt)
                ST_LOAD: w_wp_nxt  = f_ptr_inc(r_wp);
                ST_PROC: w_sub_nxt = f_sub_inc(r_sub);
                ST_OUT:  w_op_nxt  = f_ptr_inc(r_op);
                default: w_wp_nxt  = r_wp;
            endcase
        end else if (w_edge) begin
            case (r_state)
                ST_LOAD: w_wp_nxt = f_ptr_inc(r_wp);
                ST_OUT:  w_op_nxt = f_ptr_inc(r_op);
                default: w_wp_nxt = r_wp;
            endcase
        end else begin
            w_wp_nxt = r_wp;
        end
    end

    // Datapath registers: pointers, sub-phase, strobe history, sticky error.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wp      <= PTR_MAX;
            r_op      <= PTR_MAX;
            r_sub     <= SUB_MAX;
            r_chblk_q <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_wp      <= w_wp_nxt;
            r_op      <= w_op_nxt;
            r_sub     <= w_sub_nxt;
            r_chblk_q <= bus.i_chblk;
            r_err     <= r_err | ~w_legal;
        end
    end

    // Output decode from registered state and pointers. In PROC every bank
    // except the load and drain banks feeds the kernel; when wp==op only one
    // bit ends up cleared.
    always_comb begin
        w_we  = {NB{1'b0}};
        w_sel = {BW{1'b0}};
        case (r_state)
            ST_LOAD: begin
                w_we  = WE_ONE << r_wp;
                w_sel = r_wp;
            end
            ST_PROC: begin
                w_we        = {NB{1'b1}};
                w_we[r_wp]  = 1'b0;
                w_we[r_op]  = 1'b0;
                w_sel       = {BW{1'b0}};
            end
            ST_OUT: begin
                w_we  = {NB{1'b0}};
                w_sel = r_op;
            end
            default: begin
                w_we  = {NB{1'b0}};
                w_sel = {BW{1'b0}};
            end
        endcase
    end

    assign bus.o_we        = w_we;
    assign bus.o_memSelect = w_sel;
    assign bus.o_state     = r_state;
    assign bus.o_substate  = r_sub;
    assign bus.o_err       = r_err;

endmodule

// File: tb/tb_mcu_bank_ctrl.sv
// ---------------------------------------------------------------------------
// tb_mcu_bank_ctrl
// Directed vector table, hand-written corner sequences and a randomized run
// against a ring-arithmetic reference model of the bank sequencer (K=3).
// ---------------------------------------------------------------------------
module tb_mcu_bank_ctrl;
    localparam int K   = 3;
    localparam int NB  = K + 2;
    localparam int SUB = K / 2 + 1;
    localparam int BW  = ($clog2(NB)  < 1) ? 1 : $clog2(NB);
    localparam int SW  = ($clog2(SUB) < 1) ? 1 : $clog2(SUB);

    logic clk;
    logic rst;

    mcu_bank_ctrl_if #(.K(K)) bus ();

    mcu_bank_ctrl #(.K(K)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: phase as an integer (0 LOAD,1 PROC,2 OUT,3 IDLE),
    // pointers kept as plain integers modulo NB / SUB.
    int m_st, m_wp, m_op, m_sub;
    bit m_err, m_chq;

    function automatic void model_reset();
        m_st  = 3;
        m_wp  = NB - 1;
        m_op  = NB - 1;
        m_sub = SUB - 1;
        m_err = 1'b0;
        m_chq = 1'b0;
    endfunction

    function automatic void model_step(input int code, input bit chb);
        int  nxt;
        bit  ent;
        bit  edg;
        nxt = (code == 3) ? m_st : code;
        if (code == 3) m_err = 1'b1;
        ent = (code != 3) && (code != m_st);
        edg = chb && !m_chq;
        if (ent) begin
            if (nxt == 0) m_wp  = (m_wp + 1) % NB;
            if (nxt == 1) m_sub = (m_sub + 1) % SUB;
            if (nxt == 2) m_op  = (m_op + 1) % NB;
        end else if (edg) begin
            if (m_st == 0) m_wp = (m_wp + 1) % NB;
            if (m_st == 2) m_op = (m_op + 1) % NB;
        end
        m_chq = chb;
        m_st  = nxt;
    endfunction

    task automatic check_exp(input string name, input logic [1:0] st,
                             input logic [NB-1:0] we, input logic [BW-1:0] sel,
                             input logic [SW-1:0] sub, input logic err);
        checks++;
        if (bus.o_state !== st || bus.o_we !== we || bus.o_memSelect !== sel ||
            bus.o_substate !== sub || bus.o_err !== err) begin
            errors++;
            $display("FAIL %s: got state=%b we=%b sel=%0d sub=%0d err=%b, want state=%b we=%b sel=%0d sub=%0d err=%b",
                     name, bus.o_state, bus.o_we, bus.o_memSelect, bus.o_substate, bus.o_err,
                     st, we, sel, sub, err);
        end
    endtask

    task automatic check_model(input string name);
        logic [NB-1:0] we;
        logic [BW-1:0] sel;
        we  = '0;
        sel = '0;
        for (int b = 0; b < NB; b++) begin
            if (m_st == 0) we[b] = (b == m_wp);
            else if (m_st == 1) we[b] = (b != m_wp) && (b != m_op);
            else we[b] = 1'b0;
        end
        if (m_st == 0) sel = BW'(m_wp);
        else if (m_st == 2) sel = BW'(m_op);
        check_exp(name, 2'(m_st), we, sel, SW'(m_sub), m_err);
    endtask

    // One clock: inputs applied at posedge+1, model follows the edge.
    task automatic drive_cycle(input logic [1:0] code, input logic chb);
        bus.i_sop   = code[0];
        bus.i_eop   = code[1];
        bus.i_chblk = chb;
        @(posedge clk);
        model_step(int'(code), chb);
        #1;
    endtask

    // Reset raised mid-cycle; outputs are checked before any clock edge.
    task automatic async_reset(input string name);
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        check_exp(name, 2'b11, '0, '0, SW'(SUB - 1), 1'b0);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    typedef struct {
        logic [1:0]    code;
        logic          chb;
        logic [1:0]    st;
        logic [NB-1:0] we;
        logic [BW-1:0] sel;
        logic [SW-1:0] sub;
        logic          err;
    } vec_t;

    vec_t vecs[19];

    initial begin
        int saved_wp;
        logic [1:0] rcode;

        vecs[0]  = '{2'b00, 1'b0, 2'b00, 5'b00001, 3'd0, 1'b1, 1'b0};
        vecs[1]  = '{2'b00, 1'b0, 2'b00, 5'b00001, 3'd0, 1'b1, 1'b0};
        vecs[2]  = '{2'b00, 1'b0, 2'b00, 5'b00001, 3'd0, 1'b1, 1'b0};
        vecs[3]  = '{2'b00, 1'b0, 2'b00, 5'b00001, 3'd0, 1'b1, 1'b0};
        vecs[4]  = '{2'b00, 1'b1, 2'b00, 5'b00010, 3'd1, 1'b1, 1'b0};
        vecs[5]  = '{2'b00, 1'b1, 2'b00, 5'b00010, 3'd1, 1'b1, 1'b0};
        vecs[6]  = '{2'b00, 1'b1, 2'b00, 5'b00010, 3'd1, 1'b1, 1'b0};
        vecs[7]  = '{2'b00, 1'b0, 2'b00, 5'b00010, 3'd1, 1'b1, 1'b0};
        vecs[8]  = '{2'b00, 1'b1, 2'b00, 5'b00100, 3'd2, 1'b1, 1'b0};
        vecs[9]  = '{2'b10, 1'b0, 2'b10, 5'b00000, 3'd0, 1'b1, 1'b0};
        vecs[10] = '{2'b01, 1'b0, 2'b01, 5'b11010, 3'd0, 1'b0, 1'b0};
        vecs[11] = '{2'b10, 1'b0, 2'b10, 5'b00000, 3'd1, 1'b0, 1'b0};
        vecs[12] = '{2'b01, 1'b0, 2'b01, 5'b11001, 3'd0, 1'b1, 1'b0};
        vecs[13] = '{2'b11, 1'b0, 2'b01, 5'b11001, 3'd0, 1'b1, 1'b1};
        vecs[14] = '{2'b01, 1'b1, 2'b01, 5'b11001, 3'd0, 1'b1, 1'b1};
        vecs[15] = '{2'b00, 1'b0, 2'b00, 5'b01000, 3'd3, 1'b1, 1'b1};
        vecs[16] = '{2'b10, 1'b1, 2'b10, 5'b00000, 3'd2, 1'b1, 1'b1};
        vecs[17] = '{2'b10, 1'b0, 2'b10, 5'b00000, 3'd2, 1'b1, 1'b1};
        vecs[18] = '{2'b10, 1'b1, 2'b10, 5'b00000, 3'd3, 1'b1, 1'b1};

        rst         = 1'b1;
        bus.i_sop   = 1'b0;
        bus.i_eop   = 1'b0;
        bus.i_chblk = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_exp("reset", 2'b11, 5'b00000, 3'd0, 1'b1, 1'b0);
        rst = 1'b0;

        for (int i = 0; i < 19; i++) begin
            drive_cycle(vecs[i].code, vecs[i].chb);
            check_exp($sformatf("vec%0d", i), vecs[i].st, vecs[i].we,
                      vecs[i].sel, vecs[i].sub, vecs[i].err);
        end

        // Error flag survives until reset, then an in-OUT async reset.
        async_reset("async_rst_out");
        drive_cycle(2'b00, 1'b0);
        check_exp("load_after_rst", 2'b00, 5'b00001, 3'd0, 1'b1, 1'b0);

        // Five chblk edges in LOAD bring wp all the way round the ring.
        saved_wp = m_wp;
        for (int e = 0; e < 5; e++) begin
            drive_cycle(2'b00, 1'b1);
            drive_cycle(2'b00, 1'b0);
            check_model($sformatf("wrap_edge%0d", e));
        end
        check_exp("wrap_full", 2'b00, 5'b00001, BW'(saved_wp), 1'b1, 1'b0);

        // PROC with wp==op: only one kernel bank disabled.
        drive_cycle(2'b10, 1'b0);
        drive_cycle(2'b01, 1'b0);
        check_exp("proc_wp_eq_op", 2'b01, 5'b11110, 3'd0, 1'b0, 1'b0);

        // Randomized run against the model, with periodic async resets.
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 15) == 0) rcode = 2'b11;
            else rcode = 2'($urandom_range(0, 2));
            drive_cycle(rcode, 1'($urandom_range(0, 1)));
            check_model($sformatf("rand%0d", n));
            if (n % 131 == 130) async_reset($sformatf("rand_rst%0d", n));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
